// File: rtl/mio_pkg.sv
// Shared definitions for the mio / mio_rx / iob MMIO path: RX FSM states,
// port selects and port-0 status bit positions.
package mio_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic MIO_PORT_UART = 1'b0;
  localparam logic MIO_PORT_GPIO = 1'b1;

  localparam int RX_VALID_BIT = 8;
  localparam int RX_OVR_BIT   = 9;
  localparam int RX_FERR_BIT  = 10;

endpackage

// File: rtl/mio_rx_fifo.sv
// Synchronous FIFO, head visible combinationally; push while full is accepted
// only when a pop frees a slot in the same cycle. Pop on empty is ignored.
module mio_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mio_rx.sv
// 8N1 UART receiver + GPIO sampler read by iob over val/done; done and rdata
// arrive one cycle after val, and the pop / flag clear happen in the done cycle.
module mio_rx
  import mio_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int GPIO_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rxd,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              iob__mii_val,
  input  logic              iob__mii_port,
  output logic              mii__iob_done,
  output logic [31:0]       mii__iob_rdata
);
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLK_DIV - 1);

  logic              rxd_s1_q, rxd_q;
  logic [GPIO_W-1:0] gpio_s1_q, gpio_q;
  rx_state_e         state_q;
  logic [TW-1:0]     timer_q;
  logic [2:0]        idx_q;
  logic [7:0]        shift_q;
  logic              ovr_q, ferr_q, ovr_d, ferr_d;
  logic              done_q, pop_pend_q, clr_ovr_q, clr_ferr_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_head;
  logic              stop_hit, push, ovr_set, ferr_set, rd_accept, rd_uart;

  assign stop_hit  = (state_q == RX_STOP) && (timer_q == '0);
  assign push      = stop_hit && rxd_q;
  assign ferr_set  = stop_hit && !rxd_q;
  assign ovr_set   = push && fifo_full && !pop_pend_q;
  assign rd_accept = iob__mii_val && !done_q;
  assign rd_uart   = rd_accept && (iob__mii_port == MIO_PORT_UART);

  // Only flags that were reported are cleared; a flag raised meanwhile survives.
  assign ovr_d  = (ovr_q && !clr_ovr_q) || ovr_set;
  assign ferr_d = (ferr_q && !clr_ferr_q) || ferr_set;

  always_comb begin
    rdata_d = '0;
    if (iob__mii_port == MIO_PORT_GPIO) begin
      rdata_d[GPIO_W-1:0] = gpio_q;
    end else begin
      rdata_d[7:0]          = fifo_empty ? 8'h00 : fifo_head;
      rdata_d[RX_VALID_BIT] = !fifo_empty;
      rdata_d[RX_OVR_BIT]   = ovr_q;
      rdata_d[RX_FERR_BIT]  = ferr_q;
    end
  end

  mio_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop_pend_q),
    .dat_i   (shift_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_s1_q  <= 1'b1;
      rxd_q     <= 1'b1;
      gpio_s1_q <= '0;
      gpio_q    <= '0;
    end else begin
      rxd_s1_q  <= uart_rxd;
      rxd_q     <= rxd_s1_q;
      gpio_s1_q <= gpio_in;
      gpio_q    <= gpio_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (!rxd_q) begin
            timer_q <= T_HALF;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (!rxd_q) begin
            timer_q <= T_FULL;
            idx_q   <= '0;
            state_q <= RX_DATA;
          end else begin
            state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            shift_q <= {rxd_q, shift_q[7:1]};
            timer_q <= T_FULL;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (timer_q != '0) timer_q <= timer_q - 1'b1;
          else               state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      rdata_q    <= '0;
      pop_pend_q <= 1'b0;
      clr_ovr_q  <= 1'b0;
      clr_ferr_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      done_q     <= rd_accept;
      rdata_q    <= rd_accept ? rdata_d : '0;
      pop_pend_q <= rd_uart && !fifo_empty;
      clr_ovr_q  <= rd_uart && ovr_q;
      clr_ferr_q <= rd_uart && ferr_q;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign mii__iob_done  = done_q;
  assign mii__iob_rdata = rdata_q;

endmodule

// File: tb/tb_mio_rx.sv
// Directed bench for mio_rx: table of UART/GPIO stimulus and expected port reads,
// plus timed sequences for push-during-pop on a full FIFO and reset mid-frame.
module tb_mio_rx;
  localparam int CLK_DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rxd;
  logic [3:0]  gpio_in;
  logic        iob__mii_val;
  logic        iob__mii_port;
  logic        mii__iob_done;
  logic [31:0] mii__iob_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef enum int {OP_SEND, OP_SENDBAD, OP_READU, OP_READG, OP_GPIO, OP_GLITCH, OP_IDLE} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] arg;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  mio_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4), .GPIO_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rxd       (uart_rxd),
    .gpio_in        (gpio_in),
    .iob__mii_val   (iob__mii_val),
    .iob__mii_port  (iob__mii_port),
    .mii__iob_done  (mii__iob_done),
    .mii__iob_rdata (mii__iob_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic port, input logic [31:0] exp, input string nm);
    iob__mii_port = port;
    iob__mii_val  = 1'b1;
    chk({nm, " done before"}, {31'b0, mii__iob_done}, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, " done"}, {31'b0, mii__iob_done}, 32'd1);
    chk({nm, " rdata"}, mii__iob_rdata, exp);
    iob__mii_val = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " rdata idle"}, {mii__iob_rdata[31:1], mii__iob_done}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    uart_rxd      = 1'b1;
    gpio_in       = 4'h0;
    iob__mii_val  = 1'b0;
    iob__mii_port = 1'b0;

    tbl.push_back('{OP_READU,   32'h0,   32'h000});
    tbl.push_back('{OP_SEND,    32'hA5,  32'h0});
    tbl.push_back('{OP_READU,   32'h0,   32'h1A5});
    tbl.push_back('{OP_READU,   32'h0,   32'h000});
    tbl.push_back('{OP_SEND,    32'h01,  32'h0});
    tbl.push_back('{OP_SEND,    32'h02,  32'h0});
    tbl.push_back('{OP_SEND,    32'h03,  32'h0});
    tbl.push_back('{OP_READU,   32'h0,   32'h101});
    tbl.push_back('{OP_READU,   32'h0,   32'h102});
    tbl.push_back('{OP_READU,   32'h0,   32'h103});
    tbl.push_back('{OP_READU,   32'h0,   32'h000});
    for (int b = 'h10; b <= 'h14; b++) tbl.push_back('{OP_SEND, 32'(b), 32'h0});
    tbl.push_back('{OP_READU,   32'h0,   32'h310});
    tbl.push_back('{OP_READU,   32'h0,   32'h111});
    tbl.push_back('{OP_READU,   32'h0,   32'h112});
    tbl.push_back('{OP_READU,   32'h0,   32'h113});
    tbl.push_back('{OP_READU,   32'h0,   32'h000});
    tbl.push_back('{OP_SENDBAD, 32'h55,  32'h0});
    tbl.push_back('{OP_READU,   32'h0,   32'h400});
    tbl.push_back('{OP_READU,   32'h0,   32'h000});
    tbl.push_back('{OP_GLITCH,  32'h0,   32'h0});
    tbl.push_back('{OP_IDLE,    32'd40,  32'h0});
    tbl.push_back('{OP_READU,   32'h0,   32'h000});
    tbl.push_back('{OP_GPIO,    32'hA,   32'h0});
    tbl.push_back('{OP_IDLE,    32'd3,   32'h0});
    tbl.push_back('{OP_READG,   32'h0,   32'h00A});
    tbl.push_back('{OP_READU,   32'h0,   32'h000});
    for (int b = 'h20; b <= 'h23; b++) tbl.push_back('{OP_SEND, 32'(b), 32'h0});

    idle(3);
    chk("reset done", {31'b0, mii__iob_done}, 32'd0);
    chk("reset rdata", mii__iob_rdata, 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_SEND:    send_byte(tbl[i].arg[7:0], 1'b1);
        OP_SENDBAD: send_byte(tbl[i].arg[7:0], 1'b0);
        OP_READU:   do_read(1'b0, tbl[i].exp, $sformatf("vec%0d", i));
        OP_READG:   do_read(1'b1, tbl[i].exp, $sformatf("vec%0d", i));
        OP_GPIO:    gpio_in = tbl[i].arg[3:0];
        OP_GLITCH: begin
          uart_rxd = 1'b0;
          idle(4);
          uart_rxd = 1'b1;
        end
        default:    idle(int'(tbl[i].arg));
      endcase
    end

    // FIFO is full (0x20..0x23); pop lands in the same cycle as the 0x24 stop sample.
    fork
      send_byte(8'h24, 1'b1);
      begin
        idle(153);
        do_read(1'b0, 32'h120, "pop-push head");
      end
    join
    do_read(1'b0, 32'h121, "pop-push 1");
    do_read(1'b0, 32'h122, "pop-push 2");
    do_read(1'b0, 32'h123, "pop-push 3");
    do_read(1'b0, 32'h124, "pop-push kept");
    do_read(1'b0, 32'h000, "pop-push empty");

    // One-cycle reset while the receiver is on data bit 3; the line stays high afterwards.
    fork
      send_byte(8'hFC, 1'b1);
      begin
        idle(60);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end
    join
    idle(4);
    do_read(1'b0, 32'h000, "reset mid-frame");
    send_byte(8'h7E, 1'b1);
    do_read(1'b0, 32'h17E, "after reset");
    do_read(1'b0, 32'h000, "after reset empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
